// File: rtl/memfifo_data_emulator.sv
// Memory-FIFO responder: after a start edge and a fill latency it serves two tagged 64-bit words per packet.
// Build option: define MEMFIFO_EMU_PARITY_EN to carry even parity over the whole word in bit 15.
module memfifo_data_emulator #(
  parameter int unsigned FILL_DELAY = 16,
  parameter logic [15:0] SIGNATURE  = 16'hCAFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] req_packet_no,
  input  logic [15:0] req_tag,
  input  logic        memfifo_re,
  output logic        memfifo_data_ready,
  output logic [15:0] packet_no,
  output logic [63:0] memfifo_data,
  output logic        memfifo_data_valid,
  output logic        memfifo_empty,
  output logic        underflow_err,
  output logic        done
);

  localparam int unsigned PKT_W  = 16;
  localparam int unsigned WCNT_W = PKT_W + 1;
  localparam int unsigned DLY_W  = 8;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {IDLE, FILL, READY, DONE} state_t;

  state_t              state, state_d;
  logic                start_q, start_qq;
  logic [DLY_W-1:0]    delay_cnt, delay_d;
  logic [WCNT_W-1:0]   word_cnt, word_d;
  logic [WCNT_W-1:0]   total_w, total_d;
  logic [PKT_W-1:0]    cap_count, cap_count_d;
  logic [PKT_W-1:0]    cap_tag, cap_tag_d;

  logic                ready_d;
  logic [PKT_W-1:0]    packet_no_d;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d;
  logic                empty_d;
  logic                underflow_d;
  logic                done_d;

  logic                accept_c;
  logic                rd_ok_c;
  logic                last_rd_c;
  logic [WCNT_W-1:0]   word_inc_c;
  logic [DATA_W-1:0]   word_base_c;
  logic [DATA_W-1:0]   word_c;

  // Start is registered once and the rising edge detected on the registered copy.
  assign accept_c   = start_q && !start_qq && (state == IDLE);
  assign rd_ok_c    = memfifo_re && (state == READY) && (word_cnt != total_w);
  assign word_inc_c = word_cnt + WCNT_W'(1);
  assign last_rd_c  = (word_inc_c == total_w);

  assign word_base_c = {SIGNATURE, cap_tag, word_cnt[WCNT_W-1:1], 15'd0, word_cnt[0]};

`ifdef MEMFIFO_EMU_PARITY_EN
  // Bit 15 is zero in the base word, so a plain reduction gives the parity of the other 63 bits.
  assign word_c = {word_base_c[63:16], ^word_base_c, word_base_c[14:0]};
`else
  assign word_c = word_base_c;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    delay_d     = delay_cnt;
    word_d      = word_cnt;
    total_d     = total_w;
    cap_count_d = cap_count;
    cap_tag_d   = cap_tag;
    ready_d     = memfifo_data_ready;
    packet_no_d = packet_no;
    data_d      = memfifo_data;
    valid_d     = 1'b0;
    empty_d     = memfifo_empty;
    underflow_d = underflow_err;
    done_d      = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          cap_count_d = req_packet_no;
          cap_tag_d   = req_tag;
          total_d     = {req_packet_no, 1'b0};
          word_d      = '0;
          delay_d     = '0;
          underflow_d = 1'b0;
          empty_d     = (req_packet_no == '0);
          state_d     = FILL;
        end
      end
      FILL: begin
        if (delay_cnt == DLY_W'(FILL_DELAY - 1)) begin
          state_d     = READY;
          ready_d     = 1'b1;
          packet_no_d = cap_count;
        end else begin
          delay_d = delay_cnt + DLY_W'(1);
        end
      end
      READY: begin
        if (total_w == '0) begin
          state_d     = DONE;
          ready_d     = 1'b0;
          packet_no_d = '0;
          empty_d     = 1'b1;
        end else if (rd_ok_c) begin
          valid_d = 1'b1;
          data_d  = word_c;
          word_d  = word_inc_c;
          if (last_rd_c) begin
            state_d     = DONE;
            ready_d     = 1'b0;
            packet_no_d = '0;
            empty_d     = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Any read that cannot be served latches the error until the next accepted start.
    if (memfifo_re && !rd_ok_c) begin
      underflow_d = 1'b1;
    end
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      start_q            <= 1'b0;
      start_qq           <= 1'b0;
      delay_cnt          <= '0;
      word_cnt           <= '0;
      total_w            <= '0;
      cap_count          <= '0;
      cap_tag            <= '0;
      memfifo_data_ready <= 1'b0;
      packet_no          <= '0;
      memfifo_data       <= '0;
      memfifo_data_valid <= 1'b0;
      memfifo_empty      <= 1'b1;
      underflow_err      <= 1'b0;
      done               <= 1'b0;
    end else begin
      state              <= state_d;
      start_q            <= start;
      start_qq           <= start_q;
      delay_cnt          <= delay_d;
      word_cnt           <= word_d;
      total_w            <= total_d;
      cap_count          <= cap_count_d;
      cap_tag            <= cap_tag_d;
      memfifo_data_ready <= ready_d;
      packet_no          <= packet_no_d;
      memfifo_data       <= data_d;
      memfifo_data_valid <= valid_d;
      memfifo_empty      <= empty_d;
      underflow_err      <= underflow_d;
      done               <= done_d;
    end
  end

endmodule

// File: tb/tb_memfifo_data_emulator.sv
// Directed bench for memfifo_data_emulator: latency, word format, back-to-back reads, underflow, reset abort.
module tb_memfifo_data_emulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] req_packet_no;
  logic [15:0] req_tag;
  logic        memfifo_re;
  logic        memfifo_data_ready;
  logic [15:0] packet_no;
  logic [63:0] memfifo_data;
  logic        memfifo_data_valid;
  logic        memfifo_empty;
  logic        underflow_err;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  memfifo_data_emulator #(.FILL_DELAY(16), .SIGNATURE(16'hCAFE)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .req_packet_no      (req_packet_no),
    .req_tag            (req_tag),
    .memfifo_re         (memfifo_re),
    .memfifo_data_ready (memfifo_data_ready),
    .packet_no          (packet_no),
    .memfifo_data       (memfifo_data),
    .memfifo_data_valid (memfifo_data_valid),
    .memfifo_empty      (memfifo_empty),
    .underflow_err      (underflow_err),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_word(input logic [15:0] tag, input int unsigned idx);
    logic [63:0] w;
    logic [16:0] c;
    c = 17'(idx);
    w = {16'hCAFE, tag, c[16:1], 15'd0, c[0]};
`ifdef MEMFIFO_EMU_PARITY_EN
    w[15] = ^w;
`endif
    return w;
  endfunction

  task automatic check_parity();
`ifdef MEMFIFO_EMU_PARITY_EN
    check("parity_xor", 64'(^memfifo_data), 64'd0);
`else
    check("bit15_zero", 64'(memfifo_data[15]), 64'd0);
`endif
  endtask

  // Counts edges until data_ready rises; a missing rise is a failed comparison.
  task automatic wait_ready(output int n);
    n = 0;
    while (!memfifo_data_ready && n < 300) begin
      tick();
      n++;
    end
    if (!memfifo_data_ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd_pulse(input logic [15:0] tag, input int unsigned idx, input bit last);
    memfifo_re = 1'b1;
    tick();
    memfifo_re = 1'b0;
    check("rd_valid", 64'(memfifo_data_valid), 64'd1);
    check("rd_data", memfifo_data, exp_word(tag, idx));
    check_parity();
    check("rd_ready", 64'(memfifo_data_ready), 64'(!last));
    tick();
    check("rd_valid_drop", 64'(memfifo_data_valid), 64'd0);
    if (last) check("done_pulse", 64'(done), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(memfifo_data_ready), 64'd0);
    check({tag, "_empty"}, 64'(memfifo_empty), 64'd1);
    check({tag, "_valid"}, 64'(memfifo_data_valid), 64'd0);
    check({tag, "_uflow"}, 64'(underflow_err), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pkt"}, 64'(packet_no), 64'd0);
    check({tag, "_data"}, memfifo_data, 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] lit;
    rst_n = 1'b0; start = 1'b0; req_packet_no = '0; req_tag = '0; memfifo_re = 1'b0;
    tick(); tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // 3 packets, tag 0x0042, spaced reads
    req_packet_no = 16'd3; req_tag = 16'h0042;
    pulse_start();
    wait_ready(n);
    check("latency", 64'(n), 64'd17);
    check("pkt_no", 64'(packet_no), 64'd3);
    check("empty_lo", 64'(memfifo_empty), 64'd0);
    for (int i = 0; i < 6; i++) begin
      rd_pulse(16'h0042, i, i == 5);
`ifndef MEMFIFO_EMU_PARITY_EN
      if (i == 0) begin
        lit = 64'hCAFE_0042_0000_0000;
        check("first_lit", memfifo_data, lit);
      end
      if (i == 5) begin
        lit = 64'hCAFE_0042_0002_0001;
        check("last_lit", memfifo_data, lit);
      end
`endif
      if (i < 5) for (int k = 0; k < 7; k++) tick();
    end
    tick();
    check("done_one", 64'(done), 64'd0);
    check("uflow_none", 64'(underflow_err), 64'd0);
    check("empty_end", 64'(memfifo_empty), 64'd1);

    // 2 packets, re held for 4 clocks, then a 5th read underflows
    req_packet_no = 16'd2; req_tag = 16'h0010;
    pulse_start();
    wait_ready(n);
    memfifo_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_valid", 64'(memfifo_data_valid), 64'd1);
      check("b2b_data", memfifo_data, exp_word(16'h0010, i));
    end
    tick();
    memfifo_re = 1'b0;
    check("b2b_5th_valid", 64'(memfifo_data_valid), 64'd0);
    check("b2b_uflow", 64'(underflow_err), 64'd1);
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_hold", memfifo_data, exp_word(16'h0010, 3));
    tick();
    check("uflow_sticky", 64'(underflow_err), 64'd1);

    // 0 packets; read during FILL
    req_packet_no = 16'd0; req_tag = 16'h0077;
    pulse_start();
    tick();
    check("uflow_clr", 64'(underflow_err), 64'd0);
    memfifo_re = 1'b1;
    tick();
    memfifo_re = 1'b0;
    check("fill_re_uflow", 64'(underflow_err), 64'd1);
    check("fill_re_valid", 64'(memfifo_data_valid), 64'd0);
    wait_ready(n);
    check("w0_empty", 64'(memfifo_empty), 64'd1);
    check("w0_pkt", 64'(packet_no), 64'd0);
    tick();
    check("w0_ready_drop", 64'(memfifo_data_ready), 64'd0);
    check("w0_done_early", 64'(done), 64'd0);
    tick();
    check("w0_done", 64'(done), 64'd1);
    tick();
    check("w0_done_end", 64'(done), 64'd0);

    // Extra starts ignored, reset mid-transfer, fresh restart
    req_packet_no = 16'd2; req_tag = 16'h00AA;
    pulse_start();
    tick(); tick();
    req_packet_no = 16'd7; req_tag = 16'h0BAD;
    pulse_start();
    tick();
    wait_ready(n);
    check("ign_pkt", 64'(packet_no), 64'd2);
    pulse_start();
    tick();
    check("ign_ready", 64'(memfifo_data_ready), 64'd1);
    rd_pulse(16'h00AA, 0, 1'b0);
    rd_pulse(16'h00AA, 1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("abort");
    req_packet_no = 16'd2; req_tag = 16'h00AA;
    pulse_start();
    wait_ready(n);
    check("restart_pkt", 64'(packet_no), 64'd2);
    for (int i = 0; i < 4; i++) rd_pulse(16'h00AA, i, i == 3);

    // 1 packet, tag 0x0001: bit 15 carries parity only in the parity build
    req_packet_no = 16'd1; req_tag = 16'h0001;
    pulse_start();
    wait_ready(n);
    rd_pulse(16'h0001, 0, 1'b0);
    rd_pulse(16'h0001, 1, 1'b1);
    check("final_uflow", 64'(underflow_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memfifo_data_emulator.md
Name: memfifo_data_emulator

Overview:
Responder end of the memory-FIFO read interface. It emulates the DDR/memory FIFO that TOP_SERDES reads after a Data_Request. On a start it latches the requested packet count, waits a programmable fetch latency, then raises memfifo_data_ready. It then returns two deterministic 64-bit words per packet, one word per memfifo_re pulse, so the reader side can be exercised on hardware without real DDR data.

Parameters:
FILL_DELAY, 16, clocks from accepted start to memfifo_data_ready (1..255)
SIGNATURE, 16'hCAFE, constant placed in data word bits [63:48]

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  data request; rising edge (sampled vs previous clk) starts a transfer
req_packet_no  input  16  number of packets requested, captured on accepted start
req_tag  input  16  event-window tag, captured on accepted start
memfifo_re  input  1  one-clock read enable from reader
memfifo_data_ready  output  1  data available for reading
packet_no  output  16  captured packet count, valid while memfifo_data_ready
memfifo_data  output  64  read data
memfifo_data_valid  output  1  memfifo_data valid (one clock after memfifo_re)
memfifo_empty  output  1  no words left to read in current transfer
underflow_err  output  1  sticky: read attempted with no word available
done  output  1  one-clock pulse after final word presented

Behaviour:
- Reset (rst_n low at clk edge, any state, including mid-transfer): state IDLE; all outputs 0 except memfifo_empty=1; counters, captured tag/count and start edge register cleared.
- Accepted start = start high and previous-cycle start low, state IDLE only. Edges in any other state are ignored and leave no side effect.
- States:
  - IDLE: on accepted start capture req_packet_no/req_tag; total words W = 2*req_packet_no (17-bit, no overflow); clear underflow_err; go to FILL; delay_cnt=0.
  - FILL: delay_cnt increments each clock; when delay_cnt==FILL_DELAY-1 go to READY. memfifo_data_ready goes high the first cycle in READY, so it is observed FILL_DELAY+1 clocks after the start edge is sampled. packet_no output is driven with the captured count from entering READY.
  - READY: each memfifo_re with word_cnt<W is accepted. On the next clock memfifo_data_valid=1, memfifo_data = word(word_cnt), and word_cnt increments.
    - Word format: [63:48] SIGNATURE, [47:32] tag, [31:16] packet index = word_cnt>>1, [15:1] 0, [0] word_cnt[0].
    - memfifo_empty = (word_cnt==W).
    - When the final word is presented, memfifo_data_ready drops in that same cycle and state goes to DONE.
  - DONE: done=1 for exactly one clock, then IDLE. memfifo_data_ready=0 and memfifo_empty=1.
- W==0: enter READY with memfifo_empty=1; next clock go to DONE (data_ready high one cycle, done pulse follows).
- memfifo_re in IDLE, FILL, DONE, or in READY with word_cnt==W: ignored, memfifo_data_valid stays 0, underflow_err set to 1 and held until the next accepted start or reset.
- memfifo_re held high for consecutive clocks: each clock is a separate read (back-to-back valid data). The reader is not required to space its reads.
- memfifo_data holds its last value when memfifo_data_valid=0.

Optional Feature:
MEMFIFO_EMU_PARITY_EN:
- Defined: bit 15 of each word = XOR of all other 63 bits (even parity over the 64-bit word).
- Undefined: bit 15 = 0, as in the base format.
- All other bits and timing are identical in both builds.

Test Plan:
- Reset, start edge with req_packet_no=3, req_tag=16'h0042, FILL_DELAY=16 -> memfifo_data_ready high 17 clocks after the edge is sampled, packet_no=3, memfifo_empty=0.
- Then 6 memfifo_re pulses spaced 9 clocks apart -> 6 valid words, each 1 clock after its re: first 64'hCAFE_0042_0000_0000, last 64'hCAFE_0042_0002_0001. data_ready falls with the 6th word; done pulses the next clock; no underflow_err.
- req_packet_no=2 with memfifo_re held high 4 clocks -> 4 consecutive valid words, indices 0,0,1,1. A 5th re after that -> no valid, underflow_err=1 until next start.
- req_packet_no=0 -> data_ready high one cycle with memfifo_empty=1, then done pulse; memfifo_re during FILL -> underflow_err=1.
- start toggled during FILL/READY, and rst_n low for one clock after 2 of 4 words read -> extra starts ignored. Reset returns outputs to reset values; the next start runs a fresh transfer from word 0.
- MEMFIFO_EMU_PARITY_EN build, req_tag=16'h0001, 1 packet -> bit 15 of each word makes the 64-bit XOR 0. Without the macro, bit 15=0.
